// File: rtl/rx_fifo_channel.sv
// rx_fifo_channel: receive-side buffer between a VALID/READY bus and an
// upper module. First-word-fall-through FIFO with occupancy count,
// almost-full flag, synchronous flush and a wrapping accepted-beat counter.
// Every output is decoded from registered state only, so READY never
// depends combinationally on VALID, xDATA or rx_ready.
module rx_fifo_channel #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   VALID,
    output logic                   READY,
    input  logic [WIDTH-1:0]       xDATA,
    output logic [WIDTH-1:0]       rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    input  logic                   rx_flush,
    output logic [$clog2(DEPTH):0] rx_count,
    output logic                   rx_almost_full,
    output logic [15:0]            rx_beats
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

    // Storage is not reset: contents are only observable through rx_data
    // while rx_valid=1, and every readable entry has been written first.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [15:0]   beats_q,  beats_d;
    // Held low through reset so READY stays 0 until the first edge after release.
    logic          live_q,   live_d;

    logic push_s;
    logic pop_s;
    logic mem_we_s;

    // Handshake decode and output decode, all from registered state.
    always_comb begin
        READY          = live_q && (count_q < DEPTH_C);
        rx_valid       = (count_q != {CW{1'b0}});
        rx_data        = mem_q[rd_ptr_q];
        rx_count       = count_q;
        rx_almost_full = (count_q >= AF_C);
        rx_beats       = beats_q;
        push_s         = VALID && READY;
        pop_s          = rx_valid && rx_ready;
        mem_we_s       = push_s && !rx_flush;
    end

    // Next-state: pointers and count follow push/pop unless a flush wipes
    // them; the beat counter still counts a beat accepted during a flush.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        live_d   = 1'b1;
        if (push_s) begin
            beats_d = beats_q + 16'd1;
        end else begin
            beats_d = beats_q;
        end
        if (rx_flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            // DEPTH is a power of two, so natural PW-bit overflow wraps DEPTH-1 -> 0.
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with asynchronous active-high reset.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            beats_q  <= 16'd0;
            live_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            beats_q  <= beats_d;
            live_q   <= live_d;
        end
    end

    // Data storage write port; a flushed push is dropped.
    always_ff @(posedge ACLK) begin
        if (mem_we_s) begin
            mem_q[wr_ptr_q] <= xDATA;
        end
    end

endmodule

// File: tb/tb_rx_fifo_channel.sv
// Testbench for rx_fifo_channel (WIDTH=8, DEPTH=4, AF_LEVEL=3).
// A queue-based model tracks what the buffer must hold; a compare process
// checks all outputs against it on every falling edge, and the directed
// sequence adds hand-computed literal expectations at key points.
module tb_rx_fifo_channel;

    localparam int DEPTH = 4;
    localparam int AFL   = 3;

    logic       ACLK = 1'b0;
    logic       ARESET = 1'b0;
    logic       VALID = 1'b0;
    logic       READY;
    logic [7:0] xDATA = 8'd0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_flush = 1'b0;
    logic [2:0] rx_count;
    logic       rx_almost_full;
    logic [15:0] rx_beats;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Model state
    logic [7:0]  mq[$];
    logic [15:0] m_beats = 16'd0;
    bit          m_live  = 1'b0;

    rx_fifo_channel #(.WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .VALID(VALID), .READY(READY),
        .xDATA(xDATA), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .rx_flush(rx_flush), .rx_count(rx_count),
        .rx_almost_full(rx_almost_full), .rx_beats(rx_beats)
    );

    initial forever #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Model: advance on every rising edge, clear on reset.
    initial forever begin
        @(posedge ACLK or posedge ARESET);
        if (ARESET) begin
            mq.delete();
            m_beats = 16'd0;
            m_live  = 1'b0;
        end else begin
            bit acc;
            bit take;
            acc  = m_live && (mq.size() < DEPTH) && VALID;
            take = (mq.size() > 0) && rx_ready;
            if (acc) m_beats = m_beats + 16'd1;
            if (rx_flush) begin
                mq.delete();
            end else begin
                if (take) void'(mq.pop_front());
                if (acc) mq.push_back(xDATA);
            end
            m_live = 1'b1;
        end
    end

    // Compare: every falling edge, all outputs against the model.
    initial forever begin
        @(negedge ACLK);
        if (chk_en) begin
            check("m_ready",  32'(READY),          32'(m_live && (mq.size() < DEPTH)));
            check("m_valid",  32'(rx_valid),       32'(mq.size() != 0));
            check("m_count",  32'(rx_count),       32'(mq.size()));
            check("m_afull",  32'(rx_almost_full), 32'(mq.size() >= AFL));
            check("m_beats",  32'(rx_beats),       32'(m_beats));
            if (mq.size() != 0) check("m_data", 32'(rx_data), 32'(mq[0]));
        end
    end

    // One cycle: inputs applied at a falling edge, result observed at the next one.
    task automatic tick(input bit v, input logic [7:0] d, input bit r, input bit f);
        VALID = v; xDATA = d; rx_ready = r; rx_flush = f;
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    initial begin
        logic [7:0] exp_drain [4];
        exp_drain[0] = 8'h02; exp_drain[1] = 8'h03;
        exp_drain[2] = 8'h04; exp_drain[3] = 8'h05;

        #1 ARESET = 1'b1;
        VALID = 1'b1; xDATA = 8'hEE;          // beat offered during reset must be ignored
        @(negedge ACLK);
        chk_en = 1'b1;
        @(negedge ACLK);
        check("rst_ready", 32'(READY), 32'd0);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_count", 32'(rx_count), 32'd0);
        check("rst_beats", 32'(rx_beats), 32'd0);
        VALID = 1'b0;
        ARESET = 1'b0;
        check("rel_ready_pre", 32'(READY), 32'd0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        check("rel_ready", 32'(READY), 32'd1);

        // Single push, 1-cycle latency
        tick(1'b1, 8'hA1, 1'b0, 1'b0);
        check("a1_valid", 32'(rx_valid), 32'd1);
        check("a1_data",  32'(rx_data),  32'h0000_00A1);
        check("a1_count", 32'(rx_count), 32'd1);
        check("a1_beats", 32'(rx_beats), 32'd1);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        check("a1_drain", 32'(rx_count), 32'd0);

        // Fill to full
        tick(1'b1, 8'h01, 1'b0, 1'b0);
        tick(1'b1, 8'h02, 1'b0, 1'b0);
        check("fill2_af", 32'(rx_almost_full), 32'd0);
        tick(1'b1, 8'h03, 1'b0, 1'b0);
        check("fill3_af", 32'(rx_almost_full), 32'd1);
        tick(1'b1, 8'h04, 1'b0, 1'b0);
        check("full_ready", 32'(READY), 32'd0);
        check("full_count", 32'(rx_count), 32'd4);
        tick(1'b1, 8'h05, 1'b0, 1'b0);
        check("full_reject_count", 32'(rx_count), 32'd4);
        check("full_reject_beats", 32'(rx_beats), 32'd5);

        // Pop while full: push not taken that edge, READY rises after
        check("full_head", 32'(rx_data), 32'h0000_0001);
        tick(1'b1, 8'h05, 1'b1, 1'b0);
        check("pop_count", 32'(rx_count), 32'd3);
        check("pop_ready", 32'(READY), 32'd1);
        check("pop_beats", 32'(rx_beats), 32'd5);
        tick(1'b1, 8'h05, 1'b0, 1'b0);
        check("refill_count", 32'(rx_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("drain_order", 32'(rx_data), 32'(exp_drain[i]));
            tick(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("drain_empty", 32'(rx_valid), 32'd0);

        // Streaming: push and pop every cycle
        for (int i = 0; i < 10; i++) begin
            if (i > 0) check("stream_data", 32'(rx_data), 32'(8'h10 + 8'(i - 1)));
            tick(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
            check("stream_count", 32'(rx_count), 32'd1);
        end
        check("stream_last", 32'(rx_data), 32'h0000_0019);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        check("stream_beats", 32'(rx_beats), 32'd16);

        // Flush with a concurrent accepted beat
        tick(1'b1, 8'h31, 1'b0, 1'b0);
        tick(1'b1, 8'h32, 1'b0, 1'b0);
        tick(1'b1, 8'h33, 1'b0, 1'b0);
        check("preflush_count", 32'(rx_count), 32'd3);
        tick(1'b1, 8'h34, 1'b0, 1'b1);
        check("flush_count", 32'(rx_count), 32'd0);
        check("flush_valid", 32'(rx_valid), 32'd0);
        check("flush_beats", 32'(rx_beats), 32'd20);

        // Asynchronous reset mid-stream
        tick(1'b1, 8'h41, 1'b0, 1'b0);
        tick(1'b1, 8'h42, 1'b0, 1'b0);
        check("prerst_count", 32'(rx_count), 32'd2);
        VALID = 1'b1; xDATA = 8'h43;
        #2 ARESET = 1'b1;
        #1;
        check("arst_ready", 32'(READY), 32'd0);
        check("arst_valid", 32'(rx_valid), 32'd0);
        check("arst_count", 32'(rx_count), 32'd0);
        check("arst_afull", 32'(rx_almost_full), 32'd0);
        check("arst_beats", 32'(rx_beats), 32'd0);
        @(negedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        check("post_ready", 32'(READY), 32'd1);
        check("post_valid", 32'(rx_valid), 32'd0);
        check("post_beats", 32'(rx_beats), 32'd0);
        tick(1'b1, 8'h55, 1'b0, 1'b0);
        check("post_data", 32'(rx_data), 32'h0000_0055);
        tick(1'b0, 8'h00, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
